// File: rtl/lcd_fill_sequencer.sv
`default_nettype none
// ============================================================================
// lcd_fill_sequencer
//   Bus master that sends one command byte then COUNT pixels of one colour.
// Revision: 1.0
// ============================================================================
module lcd_fill_sequencer #(
  parameter int          CNT_WIDTH = 17,
  parameter int          TIMEOUT   = 1023,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [7:0]           cmd_i,
  input  logic [15:0]          color_i,
  input  logic [CNT_WIDTH-1:0] count_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_err_o,
  output logic [31:0]          spi_address_o,
  output logic                 spi_sel_o,
  output logic                 spi_read_o,
  output logic [3:0]           spi_write_mask_o,
  output logic [31:0]          spi_write_value_o,
  input  logic [31:0]          spi_read_value_i,
  input  logic                 spi_ready_i
);

  localparam logic [31:0] C_OFF_DATA   = 32'h0;
  localparam logic [31:0] C_OFF_CTRL   = 32'h4;
  localparam logic [31:0] C_OFF_STATUS = 32'h8;
  localparam logic [31:0] C_OFF_DC     = 32'hC;
  localparam int          C_PW         = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [C_PW-1:0] C_POLL_LAST = C_PW'(TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WR_DC   = 4'd1,
    S_GAP     = 4'd2,
    S_WR_DATA = 4'd3,
    S_WR_CTRL = 4'd4,
    S_POLL    = 4'd5,
    S_NEXT    = 4'd6,
    S_FINISH  = 4'd7,
    S_ERR     = 4'd8
  } state_t;

  typedef struct packed {
    logic        sel;
    logic        rd;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] wdata;
  } bus_t;

  state_t               state_q;
  state_t               gap_next_q;
  bus_t                 bus_q;
  logic [7:0]           cmd_q;
  logic [15:0]          color_q;
  logic [CNT_WIDTH:0]   rem_q;
  logic                 cmd_phase_q;
  logic                 hi_q;
  logic [C_PW-1:0]      poll_cnt_q;
  logic                 busy_q;
  logic                 done_q;
  logic                 terr_q;
  logic [7:0]           w_byte;
  logic                 unused_status;

  // Bus image presented while sitting in a given state; non-access states idle the bus.
  function automatic bus_t bus_for(input state_t s, input logic dc, input logic [7:0] b);
    bus_t r;
    r = '0;
    case (s)
      S_WR_DC:   begin r.sel = 1'b1; r.mask = 4'hF; r.addr = BASE_ADDR + C_OFF_DC;   r.wdata = {31'b0, dc}; end
      S_WR_DATA: begin r.sel = 1'b1; r.mask = 4'hF; r.addr = BASE_ADDR + C_OFF_DATA; r.wdata = {24'b0, b}; end
      S_WR_CTRL: begin r.sel = 1'b1; r.mask = 4'hF; r.addr = BASE_ADDR + C_OFF_CTRL; r.wdata = 32'd1; end
      S_POLL:    begin r.sel = 1'b1; r.rd = 1'b1;   r.addr = BASE_ADDR + C_OFF_STATUS; end
      default:   r = '0;
    endcase
    return r;
  endfunction

  assign w_byte = cmd_phase_q ? cmd_q : (hi_q ? color_q[15:8] : color_q[7:0]);
  assign unused_status = ^{spi_read_value_i[31:2], spi_read_value_i[0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      gap_next_q  <= S_IDLE;
      bus_q       <= '0;
      cmd_q       <= '0;
      color_q     <= '0;
      rem_q       <= '0;
      cmd_phase_q <= 1'b0;
      hi_q        <= 1'b0;
      poll_cnt_q  <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      terr_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            cmd_q       <= cmd_i;
            color_q     <= color_i;
            rem_q       <= {count_i, 1'b0};
            cmd_phase_q <= 1'b1;
            hi_q        <= 1'b1;
            busy_q      <= 1'b1;
            terr_q      <= 1'b0;
            state_q     <= S_WR_DC;
            bus_q       <= bus_for(S_WR_DC, 1'b0, 8'h00);
          end
        end
        S_WR_DC, S_WR_DATA, S_WR_CTRL: begin
          if (spi_ready_i) begin
            state_q    <= S_GAP;
            bus_q      <= '0;
            gap_next_q <= (state_q == S_WR_DC)   ? S_WR_DATA :
                          (state_q == S_WR_DATA) ? S_WR_CTRL : S_POLL;
          end
        end
        S_GAP: begin
          state_q    <= gap_next_q;
          bus_q      <= bus_for(gap_next_q, 1'b0, w_byte);
          poll_cnt_q <= '0;
        end
        S_POLL: begin
          if (spi_ready_i && spi_read_value_i[1]) begin
            state_q <= S_NEXT;
            bus_q   <= '0;
          end else if (poll_cnt_q == C_POLL_LAST) begin
            state_q <= S_ERR;
            bus_q   <= '0;
            terr_q  <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            poll_cnt_q <= poll_cnt_q + 1'b1;
          end
        end
        S_NEXT: begin
          if (cmd_phase_q) begin
            cmd_phase_q <= 1'b0;
            if (rem_q == '0) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_WR_DC;
              bus_q   <= bus_for(S_WR_DC, 1'b1, 8'h00);
            end
          end else begin
            // The POLL->NEXT hop already provides the idle cycle before the next DATA write.
            rem_q <= rem_q - 1'b1;
            hi_q  <= ~hi_q;
            if (rem_q == (CNT_WIDTH+1)'(1)) begin
              state_q <= S_FINISH;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
            end else begin
              state_q <= S_WR_DATA;
              bus_q   <= bus_for(S_WR_DATA, 1'b0, hi_q ? color_q[7:0] : color_q[15:8]);
            end
          end
        end
        S_FINISH: state_q <= S_IDLE;
        S_ERR:    state_q <= S_IDLE;
        default: begin
          state_q <= S_IDLE;
          bus_q   <= '0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy_o            = busy_q;
  assign done_o            = done_q;
  assign timeout_err_o     = terr_q;
  assign spi_sel_o         = bus_q.sel;
  assign spi_read_o        = bus_q.rd;
  assign spi_write_mask_o  = bus_q.mask;
  assign spi_address_o     = bus_q.addr;
  assign spi_write_value_o = bus_q.wdata;

endmodule
`default_nettype wire

// File: tb/tb_lcd_fill_sequencer.sv
`default_nettype none
// ============================================================================
// tb_lcd_fill_sequencer
//   Scoreboard bench with a behavioural SPI peripheral model.
// Revision: 1.0
// ============================================================================
module tb_lcd_fill_sequencer;

  localparam int CW = 17;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic [7:0]    cmd = '0;
  logic [15:0]   color = '0;
  logic [CW-1:0] count = '0;
  logic          busy, done, terr, sel, rd, ready;
  logic [31:0]   addr, wval, rdval;
  logic [3:0]    mask;

  always #5 clk = ~clk;

  lcd_fill_sequencer #(.CNT_WIDTH(CW), .TIMEOUT(16), .BASE_ADDR(32'h0)) dut (
    .clk(clk), .reset(reset), .start_i(start), .cmd_i(cmd), .color_i(color), .count_i(count),
    .busy_o(busy), .done_o(done), .timeout_err_o(terr),
    .spi_address_o(addr), .spi_sel_o(sel), .spi_read_o(rd), .spi_write_mask_o(mask),
    .spi_write_value_o(wval), .spi_read_value_i(rdval), .spi_ready_i(ready)
  );

  int tests = 0;
  int fails = 0;
  logic [32:0] exp_q[$];

  // peripheral model state
  logic        m_dc = 1'b0;
  logic [31:0] m_data = '0;
  logic        st_done = 1'b0;
  int          timer = 0;
  bit          never_done = 1'b0;
  int          stall_budget = 0;
  int          stall_cycles = 0;
  int          ctrl_writes = 0, dc1_writes = 0, done_pulses = 0;
  int          poll_run = 0, last_poll_run = 0;
  logic        prev_sel = 1'b0, prev_ready = 1'b1, prev_rd = 1'b0;
  logic [31:0] prev_addr = '0, prev_val = '0;

  assign rdval = {30'b0, st_done, ~st_done};

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      ready = 1'b1; st_done = 1'b0; timer = 0; poll_run = 0;
      prev_sel = 1'b0; prev_ready = 1'b1; prev_rd = 1'b0;
    end else begin
      if (sel && !rd && addr == 32'h0 && stall_cycles < stall_budget) begin
        ready = 1'b0;
        stall_cycles++;
      end else begin
        ready = 1'b1;
      end
      if (prev_sel && !prev_ready)
        check("hold_during_wait", {sel, rd, addr, wval}, {1'b1, prev_rd, prev_addr, prev_val});
      if (prev_sel && prev_ready && !prev_rd)
        check("gap_after_write", sel, 1'b0);
      if (timer > 0) begin
        timer--;
        if (timer == 0) st_done = 1'b1;
      end
      if (sel && rd) check("read_mask", mask, 4'h0);
      if (sel && ready && !rd) begin
        check("write_mask", mask, 4'hF);
        case (addr)
          32'hC: begin m_dc = wval[0]; if (wval[0]) dc1_writes++; end
          32'h0: m_data = wval;
          32'h4: begin
            ctrl_writes++;
            check("ctrl_value", wval, 32'd1);
            if (exp_q.size() == 0) begin
              tests++; fails++;
              $display("FAIL byte: got dc=%0d data=0x%0h, expected no byte", m_dc, m_data);
            end else begin
              check("byte", {m_dc, m_data}, exp_q.pop_front());
            end
            st_done = 1'b0;
            timer = never_done ? 0 : 3;
          end
          default: begin
            tests++; fails++;
            $display("FAIL write_addr: got 0x%0h, expected 0x0/0x4/0xC", addr);
          end
        endcase
      end
      if (sel && rd) poll_run++;
      else if (poll_run != 0) begin last_poll_run = poll_run; poll_run = 0; end
      if (done) begin
        done_pulses++;
        check("busy_at_done", busy, 1'b0);
      end
      prev_sel = sel; prev_ready = ready; prev_rd = rd; prev_addr = addr; prev_val = wval;
    end
  end

  task automatic push_exp(input logic [7:0] c, input logic [15:0] col, input int n);
    exp_q.push_back({1'b0, 24'b0, c});
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({1'b1, 24'b0, col[15:8]});
      exp_q.push_back({1'b1, 24'b0, col[7:0]});
    end
  endtask

  task automatic start_op(input logic [7:0] c, input logic [15:0] col, input int n);
    @(negedge clk);
    cmd = c; color = col; count = CW'(n); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check("busy_rise", busy, 1'b1);
    check("terr_cleared", terr, 1'b0);
    check("first_access_dc", {sel, rd, addr, wval}, {1'b1, 1'b0, 32'hC, 32'h0});
  endtask

  task automatic wait_done(input int p0);
    for (int k = 0; k < 3000 && done_pulses == p0; k++) begin
      @(negedge clk);
      #1;
    end
    check("done_seen", done_pulses != p0, 1'b1);
  endtask

  task automatic do_op(input logic [7:0] c, input logic [15:0] col, input int n,
                       input bit exp_to, input bit glitch);
    int c0, d0, p0, s0;
    c0 = ctrl_writes; d0 = dc1_writes; p0 = done_pulses; s0 = stall_cycles;
    push_exp(c, col, exp_to ? 0 : n);
    start_op(c, col, n);
    if (glitch) begin
      repeat (8) @(negedge clk);
      cmd = 8'h55; color = 16'h001F; count = CW'(7); start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_done(p0);
    check("timeout_err", terr, exp_to);
    check("sel_at_done", sel, 1'b0);
    if (exp_to) check("poll_cycles", last_poll_run, 16);
    check("ctrl_writes", ctrl_writes - c0, exp_to ? 1 : 1 + 2 * n);
    check("dc1_writes", dc1_writes - d0, (!exp_to && n > 0) ? 1 : 0);
    check("stall_cycles", stall_cycles - s0, stall_budget - s0);
    check("queue_drained", exp_q.size(), 0);
    repeat (3) @(negedge clk);
    #1;
    check("single_done", done_pulses - p0, 1);
    check("idle_busy", busy, 1'b0);
  endtask

  initial begin
    int c0, p0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    #1;
    check("reset_outputs", {busy, done, terr, sel, rd, mask, addr, wval}, 73'h0);

    do_op(8'h2C, 16'hF800, 2, 1'b0, 1'b0);       // basic fill
    do_op(8'h11, 16'h1234, 0, 1'b0, 1'b0);       // command only
    never_done = 1'b1;
    do_op(8'h11, 16'hABCD, 1, 1'b1, 1'b0);       // timeout abort
    never_done = 1'b0;
    do_op(8'h2A, 16'h07E0, 1, 1'b0, 1'b0);       // recovers, clears timeout_err
    stall_budget = stall_cycles + 3;
    do_op(8'h2B, 16'hA55A, 1, 1'b0, 1'b0);       // ready held low on DATA write
    do_op(8'h2C, 16'hF800, 2, 1'b0, 1'b1);       // start while busy ignored

    // reset during POLL of the third byte
    c0 = ctrl_writes; p0 = done_pulses;
    push_exp(8'h2C, 16'hF800, 2);
    start_op(8'h2C, 16'hF800, 2);
    for (int k = 0; k < 3000 && !(ctrl_writes == c0 + 3 && sel && rd); k++) begin
      @(negedge clk);
      #1;
    end
    check("reached_poll_byte3", {ctrl_writes - c0, sel, rd}, {32'd3, 1'b1, 1'b1});
    reset = 1'b1;
    @(negedge clk);
    #1;
    check("reset_abort_outputs", {busy, done, terr, sel, rd, mask, addr, wval}, 73'h0);
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    #1;
    check("no_done_on_reset", done_pulses - p0, 0);
    do_op(8'h2C, 16'hF800, 2, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
